// File: rtl/wb_design_arbiter.sv
// wb_design_arbiter: Wishbone front end that forwards bus cycles to one of
// NUM_DESIGNS hosted user designs, keeps the others in reset, owns a small
// control register window and aborts hung forwarded accesses with a watchdog.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an in-window cycle; request latched on accept
//   REG     | local register read/write, ack issued on leaving
//   FWD     | cycle forwarded to selected design, watchdog running
//   RESP    | wbs_ack_o high for one cycle with the latched data
module wb_design_arbiter #(
  parameter int          NUM_DESIGNS = 3,
  parameter int          SELW        = 2,
  parameter int          TIMEOUT     = 255,
  parameter int          RST_CYCLES  = 16,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      rst_n,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_DESIGNS-1:0]    dsn_cyc_o,
  output logic [NUM_DESIGNS-1:0]    dsn_stb_o,
  output logic                      dsn_we_o,
  output logic [3:0]                dsn_sel_o,
  output logic [31:0]               dsn_adr_o,
  output logic [31:0]               dsn_dat_o,
  input  logic [NUM_DESIGNS-1:0]    dsn_ack_i,
  input  logic [32*NUM_DESIGNS-1:0] dsn_dat_i,
  output logic [NUM_DESIGNS-1:0]    dsn_rst_n_o,
  output logic [SELW-1:0]           sel_o,
  output logic                      fail_o
);

  localparam int RCW = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REG  = 2'd1,
    ST_FWD  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic [3:0]      bsel_q, bsel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [RCW-1:0]  rc_q, rc_d;
  logic [15:0]     wd_q, wd_d;
  logic            fail_q, fail_d;
  logic [15:0]     tocnt_q, tocnt_d;

  logic            in_win;
  logic            is_reg;
  logic            ack_sel;
  logic [31:0]     rdat_sel;
  logic            rc_busy;
  logic            wr_ok;

  assign in_win  = (wbs_adr_i[31:24] == BASE_ADR[31:24]);
  assign is_reg  = (wbs_adr_i[23:20] == 4'hF);
  assign rc_busy = (rc_q != '0);
  assign wr_ok   = we_q && bsel_q[0];

  // Pick ack and read data of the selected design only; others are ignored.
  always_comb begin
    ack_sel  = 1'b0;
    rdat_sel = 32'h0;
    for (int i = 0; i < NUM_DESIGNS; i++) begin
      if (sel_q == SELW'(i)) begin
        ack_sel  = dsn_ack_i[i];
        rdat_sel = dsn_dat_i[32*i +: 32];
      end
    end
  end

  // Next-state, register access, watchdog and reset-counter logic.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = 32'h0;
    we_d    = we_q;
    bsel_d  = bsel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rc_d    = rc_busy ? rc_q - RCW'(1) : rc_q;
    wd_d    = wd_q;
    fail_d  = fail_q;
    tocnt_d = tocnt_q;
    case (state_q)
      ST_IDLE: begin
        // ack_q guard keeps a still-high strobe from being taken twice
        if (wbs_cyc_i && wbs_stb_i && in_win && !ack_q) begin
          we_d    = wbs_we_i;
          bsel_d  = wbs_sel_i;
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          wd_d    = 16'h0;
          state_d = is_reg ? ST_REG : ST_FWD;
        end
      end
      ST_REG: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
        case (adr_q[3:2])
          2'd0: begin
            if (!we_q) dat_d = {{(32-SELW){1'b0}}, sel_q};
            if (wr_ok && ({1'b0, wdat_q[SELW-1:0]} < (SELW+1)'(NUM_DESIGNS))) begin
              sel_d = wdat_q[SELW-1:0];
              rc_d  = RCW'(RST_CYCLES);
            end
          end
          2'd1: begin
            if (wr_ok && wdat_q[0]) rc_d   = RCW'(RST_CYCLES);
            if (wr_ok && wdat_q[1]) fail_d = 1'b0;
          end
          2'd2: begin
            if (!we_q) dat_d = {16'h0, 8'(NUM_DESIGNS), 6'h0, rc_busy, fail_q};
          end
          default: begin
            if (!we_q) dat_d = {16'h0, tocnt_q};
          end
        endcase
      end
      ST_FWD: begin
        // ack checked first so a coincident ack beats the timeout
        if (ack_sel) begin
          ack_d   = 1'b1;
          dat_d   = we_q ? 32'h0 : rdat_sel;
          state_d = ST_RESP;
        end else if (wd_q == 16'(TIMEOUT)) begin
          ack_d   = 1'b1;
          dat_d   = we_q ? 32'h0 : 32'hDEAD_BEEF;
          fail_d  = 1'b1;
          if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'h1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + 16'h1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any in-flight access.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      we_q    <= 1'b0;
      bsel_q  <= 4'h0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      sel_q   <= '0;
      rc_q    <= RCW'(RST_CYCLES);
      wd_q    <= 16'h0;
      fail_q  <= 1'b0;
      tocnt_q <= 16'h0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      bsel_q  <= bsel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rc_q    <= rc_d;
      wd_q    <= wd_d;
      fail_q  <= fail_d;
      tocnt_q <= tocnt_d;
    end
  end

  // One-hot cycle/strobe while forwarding; per-design reset release.
  always_comb begin
    dsn_cyc_o   = '0;
    dsn_rst_n_o = '0;
    for (int i = 0; i < NUM_DESIGNS; i++) begin
      if (sel_q == SELW'(i)) begin
        dsn_cyc_o[i]   = (state_q == ST_FWD);
        dsn_rst_n_o[i] = !rc_busy;
      end
    end
  end

  assign dsn_stb_o = dsn_cyc_o;
  assign dsn_we_o  = we_q;
  assign dsn_sel_o = bsel_q;
  assign dsn_adr_o = adr_q;
  assign dsn_dat_o = wdat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign sel_o     = sel_q;
  assign fail_o    = fail_q;

endmodule

// File: tb/tb_wb_design_arbiter.sv
// Directed bench for wb_design_arbiter with a simple per-design ack model.
module tb_wb_design_arbiter;

  localparam int N = 3;

  logic          wb_clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [N-1:0]  dsn_cyc_o, dsn_stb_o, dsn_ack_i, dsn_rst_n_o;
  logic          dsn_we_o;
  logic [3:0]    dsn_sel_o;
  logic [31:0]   dsn_adr_o, dsn_dat_o;
  logic [32*N-1:0] dsn_dat_i;
  logic [1:0]    sel_o;
  logic          fail_o;

  int n_tests = 0;
  int n_fail  = 0;

  // ack model: design d acks when its strobe has been high ack_dly[d] cycles
  int           ack_dly [N];
  int           cnt     [N];
  logic [N-1:0] ack_en    = '0;
  logic [N-1:0] ack_force = '0;

  assign dsn_dat_i = {32'h1234_5678, 32'hB1B1_1111, 32'hA0A0_0000};

  always_comb begin
    for (int d = 0; d < N; d++)
      dsn_ack_i[d] = ack_force[d] || (ack_en[d] && dsn_stb_o[d] && cnt[d] == ack_dly[d]);
  end

  always @(posedge wb_clk_i) begin
    for (int d = 0; d < N; d++)
      cnt[d] <= dsn_stb_o[d] ? cnt[d] + 1 : 0;
  end

  always #5 wb_clk_i = ~wb_clk_i;

  wb_design_arbiter dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dsn_cyc_o(dsn_cyc_o), .dsn_stb_o(dsn_stb_o), .dsn_we_o(dsn_we_o),
    .dsn_sel_o(dsn_sel_o), .dsn_adr_o(dsn_adr_o), .dsn_dat_o(dsn_dat_o),
    .dsn_ack_i(dsn_ack_i), .dsn_dat_i(dsn_dat_i), .dsn_rst_n_o(dsn_rst_n_o),
    .sel_o(sel_o), .fail_o(fail_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one Wishbone transfer starting at a falling edge; ends with the ack sample
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int max_cyc,
                         output logic [31:0] rdata, output int lat, output logic got,
                         output logic [N-1:0] stb_seen);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    got = 1'b0; lat = 0; rdata = 32'h0; stb_seen = '0;
    while (!got && lat < max_cyc) begin
      @(negedge wb_clk_i);
      lat++;
      stb_seen |= dsn_stb_o;
      if (wbs_ack_o) begin
        got = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic reg_wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    logic [31:0] rd; int lat; logic got; logic [N-1:0] sb;
    wb_xfer(1'b1, adr, dat, sel, 20, rd, lat, got, sb);
    chk({tag, "_ack"}, {31'h0, got}, 32'h1);
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd; int lat; logic got; logic [N-1:0] sb;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, 20, rd, lat, got, sb);
    chk({tag, "_lat"}, lat, 2);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd; int lat; logic got; logic [N-1:0] sb; int n;
    for (int d = 0; d < N; d++) begin ack_dly[d] = 0; end

    // 1: reset state and reset-counter release
    repeat (3) @(negedge wb_clk_i);
    chk("rst_ack_dat", {wbs_ack_o, wbs_dat_o[30:0]}, 32'h0);
    chk("rst_dsn_ctl", {22'h0, dsn_cyc_o, dsn_stb_o, dsn_we_o, dsn_sel_o}, 32'h0);
    chk("rst_dsn_adr", dsn_adr_o | dsn_dat_o, 32'h0);
    chk("rst_misc", {26'h0, sel_o, fail_o, dsn_rst_n_o}, 32'h0);
    rst_n = 1'b1;
    n = 0;
    while (dsn_rst_n_o == '0 && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("rst_release_cycles", n, 16);
    chk("rst_release_val", {29'h0, dsn_rst_n_o}, 32'h1);
    chk("rst_sel_fail", {29'h0, sel_o, fail_o}, 32'h0);
    reg_rd("tocnt_init", 32'h30F0_000C, 32'h0);

    // 2: select design 2, forwarded read acked after 3 cycles
    reg_wr("wr_sel2", 32'h30F0_0000, 32'h2, 4'hF);
    chk("sel_o_2", {30'h0, sel_o}, 32'h2);
    chk("rst_after_sel", {29'h0, dsn_rst_n_o}, 32'h0);
    repeat (20) @(negedge wb_clk_i);
    chk("rst_sel2_done", {29'h0, dsn_rst_n_o}, 32'h4);
    ack_dly[2] = 3; ack_en = 3'b100;
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 400, rd, lat, got, sb);
    chk("fwd_got", {31'h0, got}, 32'h1);
    chk("fwd_data", rd, 32'h1234_5678);
    chk("fwd_lat", lat, 5);
    chk("fwd_stb", {29'h0, sb}, 32'h4);
    chk("fwd_adr", dsn_adr_o, 32'h3000_0004);
    @(negedge wb_clk_i);
    chk("fwd_ack_1cyc", {31'h0, wbs_ack_o}, 32'h0);

    // 3: out-of-range SELECT ignored
    reg_wr("wr_sel3", 32'h30F0_0000, 32'h3, 4'hF);
    reg_rd("sel_keep", 32'h30F0_0000, 32'h2);
    chk("rst_unchanged", {29'h0, dsn_rst_n_o}, 32'h4);

    // 4: timeout, fail flag, TOCNT, fail clear
    ack_en = 3'b000;
    wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 400, rd, lat, got, sb);
    chk("to_got", {31'h0, got}, 32'h1);
    chk("to_lat", lat, 257);
    chk("to_data", rd, 32'hDEAD_BEEF);
    chk("to_fail", {31'h0, fail_o}, 32'h1);
    reg_rd("to_tocnt1", 32'h30F0_000C, 32'h1);
    reg_rd("to_status", 32'h30F0_0008, 32'h0301);
    reg_wr("wr_ctrl2", 32'h30F0_0004, 32'h2, 4'hF);
    chk("fail_clr", {31'h0, fail_o}, 32'h0);
    reg_rd("ctrl_reads0", 32'h30F0_0004, 32'h0);

    // 5: unselected design ack ignored
    reg_wr("wr_sel0", 32'h30F0_0000, 32'h0, 4'hF);
    repeat (20) @(negedge wb_clk_i);
    ack_force = 3'b010;
    wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 400, rd, lat, got, sb);
    ack_force = 3'b000;
    chk("unsel_lat", lat, 257);
    chk("unsel_data", rd, 32'hDEAD_BEEF);
    chk("unsel_stb", {29'h0, sb}, 32'h1);
    reg_rd("unsel_tocnt2", 32'h30F0_000C, 32'h2);

    // boundaries: soft reset, byte-select gating, same-value reselect, out-of-window
    reg_wr("wr_ctrl1", 32'h30F0_0004, 32'h1, 4'hF);
    chk("soft_rst", {29'h0, dsn_rst_n_o}, 32'h0);
    reg_rd("status_busy", 32'h30F0_0008, 32'h0303);
    repeat (20) @(negedge wb_clk_i);
    chk("soft_rst_done", {29'h0, dsn_rst_n_o}, 32'h1);
    reg_wr("wr_sel_nosel0", 32'h30F0_0000, 32'h1, 4'hE);
    reg_rd("sel_gated", 32'h30F0_0000, 32'h0);
    chk("rst_gated", {29'h0, dsn_rst_n_o}, 32'h1);
    reg_wr("wr_sel_same", 32'h30F0_0000, 32'h0, 4'h1);
    chk("same_sel_reload", {29'h0, dsn_rst_n_o}, 32'h0);
    wb_xfer(1'b0, 32'h2000_0000, 32'h0, 4'hF, 20, rd, lat, got, sb);
    chk("out_win_noack", {31'h0, got}, 32'h0);
    chk("out_win_nostb", {29'h0, sb}, 32'h0);

    // 6: async reset in the middle of a forwarded access
    repeat (20) @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0010; wbs_sel_i = 4'hF;
    repeat (3) @(negedge wb_clk_i);
    chk("mid_fwd_stb", {29'h0, dsn_stb_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_stb", {29'h0, dsn_stb_o}, 32'h0);
    chk("mid_rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) n++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) n++;
    end
    chk("mid_rst_no_ack", n, 0);
    reg_rd("post_rst_idle", 32'h30F0_000C, 32'h0);
    chk("post_rst_fail", {31'h0, fail_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
